aes_job_scheduler: RTL
======================

Name: aes_job_scheduler

Overview:
- Round-robin scheduler that shares one AES-128 encryption core among NUM_REQ requesters.
- Each requester presents a key/plaintext job over a valid/ready handshake. The scheduler grants one job at a time, loads it into the core, and drives the core enable. It counts the core's fixed latency, captures the ciphertext, and returns it tagged with the requester ID over a back-pressurable response channel.
- Sits between the host-side request fabric and the AES core. Its outputs connect to the core's enable, cipher-key and data inputs; the core's 128-bit result feeds back into it.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester ID width; must equal ceil(log2(NUM_REQ)).
- AES_LATENCY, 44, number of aes_en-high cycles before aes_result holds the valid ciphertext.
- CNT_W, 8, latency counter width; must satisfy 2^CNT_W > AES_LATENCY.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester job valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_key  in  NUM_REQ*128  packed keys; requester i uses bits [i*128+127 : i*128].
- req_data  in  NUM_REQ*128  packed plaintexts; same packing as req_key.
- rsp_valid  out  1  ciphertext available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  ID_W  requester index of the response.
- rsp_data  out  128  ciphertext.
- aes_en  out  1  AES core enable.
- aes_key  out  128  AES core cipher key.
- aes_data  out  128  AES core plaintext.
- aes_result  in  128  AES core output.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst_n low at a clk edge, any state): state goes to IDLE and the RR pointer goes to NUM_REQ-1. rsp_valid, rsp_id, rsp_data, aes_key, aes_data and the counter are all cleared to 0. aes_en=0, req_ready=0, busy=0. Any in-flight job is dropped with no response.
- States: IDLE, LOAD, RUN, RESP.
- IDLE:
  - Arbiter searches req_valid starting at index ptr+1, wrapping modulo NUM_REQ.
  - req_ready is one-hot at the first valid index found; req_ready=0 if no request is valid. req_ready depends combinationally on req_valid and is 0 in all other states.
  - On handshake (req_valid[g] & req_ready[g]), at the same edge: aes_key<=req_key slice g, aes_data<=req_data slice g, rsp_id<=g, ptr<=g; state goes to LOAD.
- LOAD: one cycle with aes_en=0, so the core restarts between jobs. Counter<=0; state goes to RUN.
- RUN:
  - aes_en=1; counter increments every cycle.
  - In the cycle where counter==AES_LATENCY: rsp_data<=aes_result, rsp_valid<=1, state goes to RESP.
- RESP:
  - aes_en=0. rsp_valid, rsp_id and rsp_data are held stable until rsp_ready=1.
  - On rsp_ready=1: rsp_valid<=0, state goes to IDLE.
  - No new grant occurs during RESP; the earliest next handshake is the first IDLE cycle.
- Latency: handshake in cycle t means rsp_valid is high from cycle t+AES_LATENCY+3.
- Throughput: with rsp_ready tied high, back-to-back jobs issue every AES_LATENCY+4 cycles.
- aes_key and aes_data are stable from LOAD through RESP. The scheduler never alters them while aes_en=1.
- Fairness: a requester holding req_valid is granted within NUM_REQ jobs.
- A requester may deassert req_valid without a handshake; no state change results.
- Requests arriving while busy wait; they are not queued internally.

Test Plan:
- FIPS-197 single job: requester 0 sends key 000102030405060708090a0b0c0d0e0f and data 00112233445566778899aabbccddeeff, rsp_ready=1 → rsp_valid exactly 47 cycles after the handshake, rsp_id=0, rsp_data=69c4e0d86a7b0430d8cdb78070b4c55a; busy high from LOAD through RESP.
- All four requesters valid continuously after reset, each with a distinct key/data → grant order 0,1,2,3,0; each rsp_id matches its correct ciphertext; req_ready is never multi-hot.
- Back-pressure: hold rsp_ready=0 for 20 cycles after rsp_valid → rsp_data/rsp_id stay constant, req_ready stays 0, aes_en=0; IDLE is entered one cycle after rsp_ready=1.
- Reset mid-RUN: assert rst_n=0 for one edge at counter=10 → next cycle IDLE, aes_en=0, rsp_valid=0, all outputs 0; no response for the aborted job; the next job from requester 2 completes correctly.
- Sparse requests: only requester 3 valid, then only requester 1 → granted 3 then 1 (no bubble for idle indices); ptr wraps correctly from 3 to 0.
- Key/data stability: check aes_key/aes_data every cycle while aes_en=1 → no change, even while requester inputs toggle.

Source files
------------

// File: rtl/aes_job_scheduler.sv
// Round-robin scheduler sharing one AES-128 core among NUM_REQ requesters.
// Grants one job at a time, times the core latency and returns tagged ciphertext.
module aes_job_scheduler #(
   parameter int NUM_REQ     = 4,
   parameter int ID_W        = 2,
   parameter int AES_LATENCY = 44,
   parameter int CNT_W       = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [NUM_REQ*128-1:0] req_key,
   input  logic [NUM_REQ*128-1:0] req_data,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [ID_W-1:0]        rsp_id,
   output logic [127:0]           rsp_data,
   output logic                   aes_en,
   output logic [127:0]           aes_key,
   output logic [127:0]           aes_data,
   input  logic [127:0]           aes_result,
   output logic                   busy
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

   state_t             state_q, state_d;
   logic [ID_W-1:0]    ptr_q, ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [127:0]       key_q, key_d;
   logic [127:0]       data_q, data_d;
   logic [ID_W-1:0]    id_q, id_d;
   logic [127:0]       rdata_q, rdata_d;
   logic               rvalid_q, rvalid_d;

   logic               gnt_found;
   logic [ID_W-1:0]    gnt_idx;
   logic               hs;

   // Search starts one past the last grant so every holder is served in turn.
   always_comb begin
      int j;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      j         = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         j = (int'(ptr_q) + k) % NUM_REQ;
         if (!gnt_found && req_valid[j]) begin
            gnt_found = 1'b1;
            gnt_idx   = ID_W'(j);
         end
      end
   end

   assign hs = (state_q == IDLE) && gnt_found && rst_n;

   always_comb begin
      req_ready = '0;
      if (hs) req_ready[gnt_idx] = 1'b1;
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      cnt_d    = cnt_q;
      key_d    = key_q;
      data_d   = data_q;
      id_d     = id_q;
      rdata_d  = rdata_q;
      rvalid_d = rvalid_q;
      aes_en   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (hs) begin
               key_d   = req_key[int'(gnt_idx)*128 +: 128];
               data_d  = req_data[int'(gnt_idx)*128 +: 128];
               id_d    = gnt_idx;
               ptr_d   = gnt_idx;
               state_d = LOAD;
            end
         end
         LOAD: begin
            cnt_d   = '0;
            state_d = RUN;
         end
         RUN: begin
            aes_en = 1'b1;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(AES_LATENCY)) begin
               rdata_d  = aes_result;
               rvalid_d = 1'b1;
               state_d  = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rvalid_d = 1'b0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         ptr_q    <= ID_W'(NUM_REQ - 1);
         cnt_q    <= '0;
         key_q    <= '0;
         data_q   <= '0;
         id_q     <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         cnt_q    <= cnt_d;
         key_q    <= key_d;
         data_q   <= data_d;
         id_q     <= id_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
      end
   end

   assign aes_key   = key_q;
   assign aes_data  = data_q;
   assign rsp_id    = id_q;
   assign rsp_data  = rdata_q;
   assign rsp_valid = rvalid_q;
   assign busy      = (state_q != IDLE);

endmodule
